// File: rtl/logic_proc_sequencer_if.sv
// Command/result handshake and processor button-interface bundle for logic_proc_sequencer.
// slave: the sequencer side; master: the host and processor side.
interface logic_proc_sequencer_if;
  localparam int unsigned DW = 8;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic          cmd_lda;
  logic          cmd_ldb;
  logic [2:0]    cmd_f;
  logic [1:0]    cmd_r;

  logic [DW-1:0] Din;
  logic          loadA;
  logic          loadB;
  logic          execute;
  logic [2:0]    F;
  logic [1:0]    R;
  logic [DW-1:0] Aval;
  logic [DW-1:0] Bval;

  logic          res_valid;
  logic [DW-1:0] res_a;
  logic [DW-1:0] res_b;
  logic          res_err;
  logic [DW-1:0] err_cnt;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_lda, cmd_ldb, cmd_f, cmd_r, Aval, Bval,
    output cmd_ready, Din, loadA, loadB, execute, F, R,
           res_valid, res_a, res_b, res_err, err_cnt
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_lda, cmd_ldb, cmd_f, cmd_r, Aval, Bval,
    input  cmd_ready, Din, loadA, loadB, execute, F, R,
           res_valid, res_a, res_b, res_err, err_cnt
  );
endinterface

// File: rtl/logic_proc_sequencer.sv
// Command-driven sequencer for the bit-serial logic processor: strobes loadA/loadB/execute,
// drives Din/F/R and captures Aval/Bval. Optional result checker: LOGIC_PROC_CHECK_EN.
module logic_proc_sequencer #(
  parameter int unsigned PULSE_CYCLES  = 1,
  parameter int unsigned EXEC_CYCLES   = 11,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                   clk,
  input logic                   reset,
  logic_proc_sequencer_if.slave bus
);
  localparam int unsigned DW         = 8;
  localparam int unsigned MAX_A      = (PULSE_CYCLES > EXEC_CYCLES) ? PULSE_CYCLES : EXEC_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;
  // Execute stays high through RESULT as well, so EXEC_HI itself is one settle cycle shorter.
  localparam int unsigned HI_CYCLES  = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LDA_LO, S_LDA_HI, S_LDB_LO, S_LDB_HI, S_EXEC_LO, S_EXEC_HI, S_RESULT
  } state_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          ldb;
    logic [2:0]    f;
    logic [1:0]    r;
  } cmd_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmd_t          cmd_q, cmd_d;
  logic          ready_q, ready_d;
  logic          load_a_q, load_a_d, load_b_q, load_b_d, exec_q, exec_d;
  logic [DW-1:0] din_q, din_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_a_q, res_a_d, res_b_q, res_b_d;
  logic          capture_c;

  // Reload value of the shared down-counter for each timed state.
  function automatic logic [CW-1:0] dur(input state_t s);
    case (s)
      S_LDA_LO, S_LDB_LO: dur = CW'(PULSE_CYCLES - 1);
      S_EXEC_LO:          dur = CW'(EXEC_CYCLES - 1);
      S_EXEC_HI:          dur = CW'(HI_CYCLES - 1);
      default:            dur = '0;
    endcase
  endfunction

  assign capture_c = (state_q == S_EXEC_HI) && (cnt_q == '0);

  // Next state, counter and next registered outputs (decoded from the next state).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    res_a_d     = res_a_q;
    res_b_d     = res_b_q;
    case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        cmd_d   = '{a: bus.cmd_a, b: bus.cmd_b, ldb: bus.cmd_ldb, f: bus.cmd_f, r: bus.cmd_r};
        state_d = bus.cmd_lda ? S_LDA_LO : (bus.cmd_ldb ? S_LDB_LO : S_EXEC_LO);
      end
      S_LDA_LO:  if (cnt_q == '0) state_d = S_LDA_HI;  else cnt_d = cnt_q - CW'(1);
      S_LDA_HI:  state_d = cmd_q.ldb ? S_LDB_LO : S_EXEC_LO;
      S_LDB_LO:  if (cnt_q == '0) state_d = S_LDB_HI;  else cnt_d = cnt_q - CW'(1);
      S_LDB_HI:  state_d = S_EXEC_LO;
      S_EXEC_LO: if (cnt_q == '0) state_d = S_EXEC_HI; else cnt_d = cnt_q - CW'(1);
      S_EXEC_HI: if (capture_c) begin
        state_d = S_RESULT;
        res_a_d = bus.Aval;
        res_b_d = bus.Bval;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      S_RESULT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = dur(state_d);

    ready_d     = (state_d == S_IDLE);
    load_a_d    = (state_d != S_LDA_LO);
    load_b_d    = (state_d != S_LDB_LO);
    exec_d      = (state_d != S_EXEC_LO);
    res_valid_d = (state_d == S_RESULT);
    if (state_d == S_LDA_LO || state_d == S_LDA_HI)      din_d = cmd_d.a;
    else if (state_d == S_LDB_LO || state_d == S_LDB_HI) din_d = cmd_d.b;
    else                                                 din_d = '0;
  end

  // State and output registers; reset forces every strobe high at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      ready_q     <= 1'b1;
      load_a_q    <= 1'b1;
      load_b_q    <= 1'b1;
      exec_q      <= 1'b1;
      din_q       <= '0;
      res_valid_q <= 1'b0;
      res_a_q     <= '0;
      res_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      ready_q     <= ready_d;
      load_a_q    <= load_a_d;
      load_b_q    <= load_b_d;
      exec_q      <= exec_d;
      din_q       <= din_d;
      res_valid_q <= res_valid_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.loadA     = load_a_q;
  assign bus.loadB     = load_b_q;
  assign bus.execute   = exec_q;
  assign bus.Din       = din_q;
  assign bus.F         = cmd_q.f;
  assign bus.R         = cmd_q.r;
  assign bus.res_valid = res_valid_q;
  assign bus.res_a     = res_a_q;
  assign bus.res_b     = res_b_q;

`ifdef LOGIC_PROC_CHECK_EN
  logic [DW-1:0] sa_q, sa_d, sb_q, sb_d, f_val, exp_a, exp_b;
  logic          err_q, err_d, mism;
  logic [DW-1:0] err_cnt_q, err_cnt_d;

  // Shadow model of the processor registers and result comparison at capture.
  always_comb begin
    sa_d      = sa_q;
    sb_d      = sb_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    case (cmd_q.f)
      3'b000:  f_val = sa_q & sb_q;
      3'b001:  f_val = sa_q | sb_q;
      3'b010:  f_val = sa_q ^ sb_q;
      3'b011:  f_val = '1;
      3'b100:  f_val = ~(sa_q & sb_q);
      3'b101:  f_val = ~(sa_q | sb_q);
      3'b110:  f_val = ~(sa_q ^ sb_q);
      default: f_val = '0;
    endcase
    case (cmd_q.r)
      2'b00:   begin exp_a = sa_q;  exp_b = sb_q;  end
      2'b01:   begin exp_a = sa_q;  exp_b = f_val; end
      2'b10:   begin exp_a = f_val; exp_b = sb_q;  end
      default: begin exp_a = sb_q;  exp_b = sa_q;  end
    endcase
    mism = (bus.Aval != exp_a) || (bus.Bval != exp_b);
    if (state_q == S_LDA_LO) sa_d = cmd_q.a;
    if (state_q == S_LDB_LO) sb_d = cmd_q.b;
    if (capture_c) begin
      err_d = mism;
      if (mism && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      sa_d = exp_a;
      sb_d = exp_b;
    end
  end

  // Checker registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sa_q      <= '0;
      sb_q      <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.res_err = err_q;
  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.res_err = 1'b0;
  assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_logic_proc_sequencer.sv
// Self-checking bench for logic_proc_sequencer with a behavioural processor and reference model.
module tb_logic_proc_sequencer;
  localparam int PULSE = 1, EXEC = 11, SETTLE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_proc_sequencer_if bus();

  logic_proc_sequencer #(.PULSE_CYCLES(PULSE), .EXEC_CYCLES(EXEC), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  int checks = 0, errors = 0;

  // Logic function and routing as the processor defines them.
  function automatic logic [7:0] fn(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      3'd0: return a & b;     3'd1: return a | b;
      3'd2: return a ^ b;     3'd3: return 8'hFF;
      3'd4: return ~(a & b);  3'd5: return ~(a | b);
      3'd6: return ~(a ^ b);  default: return 8'h00;
    endcase
  endfunction
  function automatic logic [15:0] route(input logic [1:0] r, input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] y);
    case (r)
      2'd0: return {a, b};  2'd1: return {a, y};
      2'd2: return {y, b};  default: return {b, a};
    endcase
  endfunction

  // Processor stand-in: loads on low strobes, computes 8 cycles after execute falls.
  logic [7:0] pa, pb;
  logic prev_ex, stuck = 1'b0;
  int pcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa <= 8'h00; pb <= 8'h00; prev_ex <= 1'b1; pcnt <= 0;
    end else begin
      prev_ex <= bus.execute;
      if (!bus.loadA) pa <= bus.Din;
      if (!bus.loadB) pb <= bus.Din;
      if (prev_ex && !bus.execute) pcnt <= 8;
      else if (pcnt != 0) begin
        pcnt <= pcnt - 1;
        if (pcnt == 1) {pa, pb} <= route(bus.R, pa, pb, fn(bus.F, pa, pb));
      end
    end
  end
  assign bus.Aval = pa;
  assign bus.Bval = stuck ? 8'h00 : pb;

  // Reference model state and expectations for the current command.
  logic [7:0] ref_a = 8'h00, ref_b = 8'h00, exp_ra, exp_rb, exp_ec = 8'h00;
  logic exp_re;
  int exp_rv, exp_la, exp_lb, exp_ex0;

  task automatic model_cmd(input logic [7:0] a, input logic [7:0] b, input logic lda, input logic ldb,
                           input logic [2:0] f, input logic [1:0] r);
    int nl;
    logic mism;
    if (lda) ref_a = a;
    if (ldb) ref_b = b;
    {ref_a, ref_b} = route(r, ref_a, ref_b, fn(f, ref_a, ref_b));
    exp_ra = ref_a;
    exp_rb = stuck ? 8'h00 : ref_b;
    mism = (exp_rb != ref_b);
`ifdef LOGIC_PROC_CHECK_EN
    exp_re = mism;
    if (mism && exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
`else
    exp_re = 1'b0;
    exp_ec = 8'h00;
`endif
    nl      = int'(lda) + int'(ldb);
    exp_rv  = nl * (PULSE + 1) + EXEC + SETTLE;
    exp_ex0 = nl * (PULSE + 1) + 1;
    exp_la  = lda ? 1 : -1;
    exp_lb  = ldb ? (lda ? PULSE + 2 : 1) : -1;
  endtask

  // Measurements from the last command.
  int m_la, m_lb, m_ex0, m_exn, m_rv, m_viol;
  logic m_ready0, m_ready1, m_ready2, m_rv2, m_re;
  logic [7:0] m_dina, m_dinb, m_ra, m_rb, m_ec;
  logic [2:0] m_f, prev_low = 3'b000;
  logic [1:0] m_r;

  // Issue one command at a negedge in IDLE and observe it until one cycle after res_valid.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic lda, input logic ldb,
                         input logic [2:0] f, input logic [1:0] r, input logic hold);
    int cyc;
    logic [2:0] low;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_lda = lda; bus.cmd_ldb = ldb;
    bus.cmd_f = f; bus.cmd_r = r; bus.cmd_valid = 1'b1;
    m_ready0 = bus.cmd_ready;
    @(negedge clk);
    cyc = 1;
    m_ready1 = bus.cmd_ready;
    if (!hold) bus.cmd_valid = 1'b0;
    m_la = -1; m_lb = -1; m_ex0 = -1; m_exn = 0; m_rv = -1; m_viol = 0;
    while (cyc <= 80 && m_rv < 0) begin
      low = {!bus.loadA, !bus.loadB, !bus.execute};
      if ($countones(low) > 1) m_viol++;
      if (low != 3'b000 && prev_low != 3'b000 && low != prev_low) m_viol++;
      prev_low = low;
      if (!bus.loadA && m_la < 0) begin m_la = cyc; m_dina = bus.Din; end
      if (!bus.loadB && m_lb < 0) begin m_lb = cyc; m_dinb = bus.Din; end
      if (!bus.execute) begin if (m_ex0 < 0) m_ex0 = cyc; m_exn++; end
      if (bus.res_valid) begin
        m_rv = cyc; m_ra = bus.res_a; m_rb = bus.res_b; m_re = bus.res_err;
        m_ec = bus.err_cnt; m_f = bus.F; m_r = bus.R;
      end
      if (hold && m_rv < 0) begin
        bus.cmd_a = 8'($urandom); bus.cmd_b = 8'($urandom); bus.cmd_lda = 1'($urandom);
        bus.cmd_ldb = 1'($urandom); bus.cmd_f = 3'($urandom); bus.cmd_r = 2'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    m_ready2 = bus.cmd_ready;
    m_rv2 = bus.res_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.cmd_lda = 1'b0; bus.cmd_ldb = 1'b0; bus.cmd_f = '0; bus.cmd_r = '0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.cmd_ready, bus.loadA, bus.loadB, bus.execute} !== 4'b1111) begin
      errors++; $display("FAIL reset_strobes: ready/lA/lB/ex=%b want 1111", {bus.cmd_ready, bus.loadA, bus.loadB, bus.execute}); end
    checks++; if ({bus.Din, bus.F, bus.R} !== 13'd0) begin
      errors++; $display("FAIL reset_din_f_r: Din=%h F=%b R=%b want 0", bus.Din, bus.F, bus.R); end
    checks++; if ({bus.res_valid, bus.res_a, bus.res_b, bus.res_err, bus.err_cnt} !== 26'd0) begin
      errors++; $display("FAIL reset_results: rv=%b a=%h b=%h err=%b cnt=%h want 0", bus.res_valid, bus.res_a, bus.res_b, bus.res_err, bus.err_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_directed();
    logic [7:0] ta [3] = '{8'h33, 8'h00, 8'h00};
    logic [7:0] tb [3] = '{8'h55, 8'h00, 8'h00};
    logic       tl [3] = '{1'b1, 1'b0, 1'b0};
    logic [2:0] tf [3] = '{3'b010, 3'b110, 3'b000};
    logic [1:0] tr [3] = '{2'b10, 2'b01, 2'b11};
    logic [7:0] xa [3] = '{8'h66, 8'h66, 8'hCC};
    logic [7:0] xb [3] = '{8'h55, 8'hCC, 8'h66};
    for (int i = 0; i < 3; i++) begin
      model_cmd(ta[i], tb[i], tl[i], tl[i], tf[i], tr[i]);
      run_cmd(ta[i], tb[i], tl[i], tl[i], tf[i], tr[i], 1'b0);
      checks++; if (m_ready0 !== 1'b1 || m_ready1 !== 1'b0 || m_ready2 !== 1'b1) begin
        errors++; $display("FAIL dir%0d_ready: before/after/end=%b%b%b want 101", i, m_ready0, m_ready1, m_ready2); end
      checks++; if (m_rv != exp_rv || m_rv2 !== 1'b0) begin
        errors++; $display("FAIL dir%0d_latency: res_valid cycle %0d (next %b) want %0d (next 0)", i, m_rv, m_rv2, exp_rv); end
      checks++; if (m_la != exp_la || m_lb != exp_lb) begin
        errors++; $display("FAIL dir%0d_load_cycles: loadA %0d loadB %0d want %0d %0d", i, m_la, m_lb, exp_la, exp_lb); end
      checks++; if (tl[i] && (m_dina !== ta[i] || m_dinb !== tb[i])) begin
        errors++; $display("FAIL dir%0d_din: %h/%h want %h/%h", i, m_dina, m_dinb, ta[i], tb[i]); end
      checks++; if (m_ex0 != exp_ex0 || m_exn != EXEC) begin
        errors++; $display("FAIL dir%0d_exec: start %0d len %0d want %0d %0d", i, m_ex0, m_exn, exp_ex0, EXEC); end
      checks++; if (m_ra !== xa[i] || m_rb !== xb[i] || m_ra !== exp_ra || m_rb !== exp_rb) begin
        errors++; $display("FAIL dir%0d_result: a=%h b=%h want a=%h b=%h", i, m_ra, m_rb, xa[i], xb[i]); end
      checks++; if (m_re !== 1'b0 || m_ec !== 8'h00) begin
        errors++; $display("FAIL dir%0d_err: err=%b cnt=%h want 0 00", i, m_re, m_ec); end
      checks++; if (m_viol != 0) begin errors++; $display("FAIL dir%0d_strobe_gap: %0d violations want 0", i, m_viol); end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b; logic la, lb; logic [2:0] f; logic [1:0] r;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); la = 1'($urandom); lb = 1'($urandom);
      f = 3'($urandom); r = 2'($urandom);
      model_cmd(a, b, la, lb, f, r);
      run_cmd(a, b, la, lb, f, r, 1'b0);
      checks++; if (m_rv != exp_rv || m_ex0 != exp_ex0 || m_exn != EXEC || m_la != exp_la || m_lb != exp_lb) begin
        errors++; $display("FAIL rnd%0d_timing: rv %0d ex %0d/%0d lA %0d lB %0d want %0d %0d/%0d %0d %0d", i, m_rv, m_ex0, m_exn, m_la, m_lb, exp_rv, exp_ex0, EXEC, exp_la, exp_lb); end
      checks++; if (m_ra !== exp_ra || m_rb !== exp_rb || m_re !== exp_re || m_ec !== exp_ec) begin
        errors++; $display("FAIL rnd%0d_result: a=%h b=%h err=%b cnt=%h want %h %h %b %h", i, m_ra, m_rb, m_re, m_ec, exp_ra, exp_rb, exp_re, exp_ec); end
      checks++; if (m_viol != 0 || m_ready2 !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_gap_ready: viol %0d ready %b want 0 1", i, m_viol, m_ready2); end
    end
  endtask

  task automatic test_stuck_b();
    logic [7:0] a, b;
    stuck = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      model_cmd(a, b, 1'b1, 1'b1, 3'b011, 2'b01);
      run_cmd(a, b, 1'b1, 1'b1, 3'b011, 2'b01, 1'b0);
      checks++; if (m_rv != exp_rv || m_ra !== exp_ra || m_rb !== exp_rb || m_re !== exp_re || m_ec !== exp_ec) begin
        errors++; $display("FAIL stuck%0d: rv %0d a=%h b=%h err=%b cnt=%h want %0d %h %h %b %h", i, m_rv, m_ra, m_rb, m_re, m_ec, exp_rv, exp_ra, exp_rb, exp_re, exp_ec); end
    end
`ifdef LOGIC_PROC_CHECK_EN
    checks++; if (m_ec !== 8'hFF) begin errors++; $display("FAIL stuck_saturate: cnt=%h want ff", m_ec); end
`endif
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    int waitc = 0, rv_seen = 0;
    bus.cmd_a = 8'hA5; bus.cmd_b = 8'h5A; bus.cmd_lda = 1'b1; bus.cmd_ldb = 1'b1;
    bus.cmd_f = 3'b001; bus.cmd_r = 2'b10; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    while (bus.execute !== 1'b0 && waitc < 40) begin @(negedge clk); waitc++; end
    checks++; if (bus.execute !== 1'b0) begin errors++; $display("FAIL rstmid_exec_low: execute=%b want 0", bus.execute); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.execute, bus.loadA, bus.loadB} !== 3'b111) begin
      errors++; $display("FAIL rstmid_async_strobes: ex/lA/lB=%b want 111", {bus.execute, bus.loadA, bus.loadB}); end
    ref_a = 8'h00; ref_b = 8'h00; exp_ec = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1 || bus.err_cnt !== exp_ec) begin
      errors++; $display("FAIL rstmid_ready: ready=%b cnt=%h want 1 %h", bus.cmd_ready, bus.err_cnt, exp_ec); end
    for (int i = 0; i < 30; i++) begin if (bus.res_valid) rv_seen++; @(negedge clk); end
    checks++; if (rv_seen != 0) begin errors++; $display("FAIL rstmid_no_result: %0d res_valid cycles want 0", rv_seen); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b; logic la, lb; logic [2:0] f; logic [1:0] r;
    prev_low = 3'b000;
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); b = 8'($urandom); la = 1'($urandom); lb = 1'($urandom);
      f = 3'($urandom); r = 2'($urandom);
      model_cmd(a, b, la, lb, f, r);
      run_cmd(a, b, la, lb, f, r, 1'b1);
      checks++; if (m_ready0 !== 1'b1 || m_ready1 !== 1'b0 || m_rv != exp_rv) begin
        errors++; $display("FAIL b2b%0d_accept: ready %b/%b rv %0d want 1/0 %0d", i, m_ready0, m_ready1, m_rv, exp_rv); end
      checks++; if (m_ra !== exp_ra || m_rb !== exp_rb || m_f !== f || m_r !== r) begin
        errors++; $display("FAIL b2b%0d_result: a=%h b=%h F=%b R=%b want %h %h %b %b", i, m_ra, m_rb, m_f, m_r, exp_ra, exp_rb, f, r); end
      checks++; if (m_viol != 0) begin errors++; $display("FAIL b2b%0d_strobe_gap: %0d violations want 0", i, m_viol); end
    end
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stuck_b();
    test_reset_mid_exec();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
